// File: rtl/mcycle_unit_pkg.sv
// ============================================================================
// Module   : mcycle_unit_pkg
// Brief    : Shared MCycleOp encodings, FSM state type and op-decode helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mcycle_unit_pkg;

   localparam logic [1:0] OP_SMUL = 2'b00;
   localparam logic [1:0] OP_UMUL = 2'b01;
   localparam logic [1:0] OP_SDIV = 2'b10;
   localparam logic [1:0] OP_UDIV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COMPUTING = 2'd1,
      ST_DONE      = 2'd2
   } state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_SDIV) || (op == OP_UDIV);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_SMUL) || (op == OP_SDIV);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mcycle_unit_if.sv
// ============================================================================
// Module   : mcycle_unit_if
// Brief    : Request/result/stall bundle between the core and mcycle_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mcycle_unit_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [1:0]       MCycleOp;
   logic [WIDTH-1:0] Operand1;
   logic [WIDTH-1:0] Operand2;
   logic [WIDTH-1:0] Result1;
   logic [WIDTH-1:0] Result2;
   logic             Busy;

   modport master (
      output Start, MCycleOp, Operand1, Operand2,
      input  Result1, Result2, Busy
   );

   modport slave (
      input  Start, MCycleOp, Operand1, Operand2,
      output Result1, Result2, Busy
   );
endinterface

`default_nettype wire

// File: rtl/mcycle_step.sv
// ============================================================================
// Module   : mcycle_step
// Brief    : One combinational shift-add (MUL) or restoring shift-subtract (DIV) iteration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mcycle_step #(
   parameter int WIDTH = 32
) (
   input  logic               i_is_div,
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_op_a,
   input  logic [WIDTH-1:0]   i_op_b,
   output logic [2*WIDTH-1:0] o_acc,
   output logic [WIDTH-1:0]   o_op_b
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_s;
   logic [WIDTH:0] diff;

   always_comb begin
      // MUL: acc = {partial product hi, shifted-in product lo}; right-shift form
      sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_op_b[0] ? {1'b0, i_op_a} : '0);
      // DIV: acc = {remainder, dividend/quotient}; borrow in diff[WIDTH] means restore
      rem_s = i_acc[2*WIDTH-1:WIDTH-1];
      diff  = rem_s - {1'b0, i_op_a};
      if (i_is_div) begin
         o_op_b = i_op_b;
         if (diff[WIDTH]) begin
            o_acc = {rem_s[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
         end else begin
            o_acc = {diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
         end
      end else begin
         o_op_b = i_op_b >> 1;
         o_acc  = {sum, i_acc[WIDTH-1:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/mcycle_unit.sv
// ============================================================================
// Module   : mcycle_unit
// Brief    : Iterative signed/unsigned MUL/DIV unit; one step per clock, WIDTH+1 Busy cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mcycle_unit
   import mcycle_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic         CLK,
   input  logic         RESET,
   mcycle_unit_if.slave bus
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_e               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     op_a_q, op_a_d;
   logic [WIDTH-1:0]     op_b_q, op_b_d;
   logic [WIDTH-1:0]     orig1_q, orig1_d;
   logic                 is_div_q, is_div_d;
   logic                 neg1_q, neg1_d;
   logic                 neg2_q, neg2_d;
   logic                 div_zero_q, div_zero_d;
   logic [WIDTH-1:0]     result1_q, result1_d;
   logic [WIDTH-1:0]     result2_q, result2_d;

   logic                 in_signed, in_neg1, in_neg2, in_is_div;
   logic [WIDTH-1:0]     in_mag1, in_mag2;
   logic [2*WIDTH-1:0]   step_acc;
   logic [WIDTH-1:0]     step_op_b;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quot_fix, rem_fix;
   logic [WIDTH-1:0]     fix_r1, fix_r2;
   logic                 busy;

   mcycle_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div (is_div_q),
      .i_acc    (acc_q),
      .i_op_a   (op_a_q),
      .i_op_b   (op_b_q),
      .o_acc    (step_acc),
      .o_op_b   (step_op_b)
   );

   always_comb begin : operand_prep
      in_is_div = op_is_div(bus.MCycleOp);
      in_signed = op_is_signed(bus.MCycleOp);
      in_neg1   = in_signed & bus.Operand1[WIDTH-1];
      in_neg2   = in_signed & bus.Operand2[WIDTH-1];
      in_mag1   = in_neg1 ? -bus.Operand1 : bus.Operand1;
      in_mag2   = in_neg2 ? -bus.Operand2 : bus.Operand2;
   end

   // Sign correction on the final step output, so results load on the DONE edge
   always_comb begin : sign_fix
      prod_fix = (neg1_q ^ neg2_q) ? -step_acc : step_acc;
      quot_fix = (neg1_q ^ neg2_q) ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
      rem_fix  = neg1_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
      if (!is_div_q) begin
         fix_r1 = prod_fix[WIDTH-1:0];
         fix_r2 = prod_fix[2*WIDTH-1:WIDTH];
      end else if (div_zero_q) begin
         fix_r1 = '1;
         fix_r2 = orig1_q;
      end else begin
         fix_r1 = quot_fix;
         fix_r2 = rem_fix;
      end
   end

   always_comb begin : next_state
      state_d    = state_q;
      count_d    = count_q;
      acc_d      = acc_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      orig1_d    = orig1_q;
      is_div_d   = is_div_q;
      neg1_d     = neg1_q;
      neg2_d     = neg2_q;
      div_zero_d = div_zero_q;
      result1_d  = result1_q;
      result2_d  = result2_q;
      busy       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.Start) begin
               busy       = 1'b1;
               state_d    = ST_COMPUTING;
               count_d    = '0;
               is_div_d   = in_is_div;
               neg1_d     = in_neg1;
               neg2_d     = in_neg2;
               div_zero_d = in_is_div && (bus.Operand2 == '0);
               orig1_d    = bus.Operand1;
               op_a_d     = in_is_div ? in_mag2 : in_mag1;
               op_b_d     = in_mag2;
               acc_d      = in_is_div ? {{WIDTH{1'b0}}, in_mag1} : '0;
            end
         end
         ST_COMPUTING: begin
            busy    = 1'b1;
            acc_d   = step_acc;
            op_b_d  = step_op_b;
            count_d = count_q + CW'(1);
            if (count_q == LAST) begin
               state_d   = ST_DONE;
               result1_d = fix_r1;
               result2_d = fix_r2;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         acc_q      <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         orig1_q    <= '0;
         is_div_q   <= 1'b0;
         neg1_q     <= 1'b0;
         neg2_q     <= 1'b0;
         div_zero_q <= 1'b0;
         result1_q  <= '0;
         result2_q  <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         acc_q      <= acc_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         orig1_q    <= orig1_d;
         is_div_q   <= is_div_d;
         neg1_q     <= neg1_d;
         neg2_q     <= neg2_d;
         div_zero_q <= div_zero_d;
         result1_q  <= result1_d;
         result2_q  <= result2_d;
      end
   end

   assign bus.Busy    = busy;
   assign bus.Result1 = result1_q;
   assign bus.Result2 = result2_q;

endmodule

`default_nettype wire

// File: tb/tb_mcycle_unit.sv
// ============================================================================
// Module   : tb_mcycle_unit
// Brief    : Directed-vector bench for mcycle_unit with a queue-based result scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mcycle_unit;
   import mcycle_unit_pkg::*;

   localparam int WIDTH       = 32;
   localparam int BUSY_CYCLES = WIDTH + 1;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   always #5 CLK = ~CLK;

   mcycle_unit_if #(.WIDTH(WIDTH)) bus ();

   mcycle_unit #(.WIDTH(WIDTH)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] r1;
      logic [31:0] r2;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks     = 0;
   int   errors     = 0;
   int   busy_run   = 0;
   logic prev_busy  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a falling Busy edge marks a retiring op; compare against the queue head
   always @(negedge CLK) begin
      if (RESET) begin
         busy_run  = 0;
         prev_busy = 1'b0;
      end else begin
         if (bus.Busy) begin
            busy_run++;
         end else if (prev_busy) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 64'd1, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               check({mon_e.name, "_r1"}, {32'd0, bus.Result1}, {32'd0, mon_e.r1});
               check({mon_e.name, "_r2"}, {32'd0, bus.Result2}, {32'd0, mon_e.r2});
               check({mon_e.name, "_busy_cycles"}, 64'(busy_run), 64'(BUSY_CYCLES));
            end
            busy_run = 0;
         end
         prev_busy = bus.Busy;
      end
   end

   task automatic wait_busy_low(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (!bus.Busy) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({name, "_timeout"}, 64'd1, 64'd0);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r1, input logic [31:0] r2, input string name);
      exp_t e;
      @(posedge CLK); #1;
      bus.Start    = 1'b1;
      bus.MCycleOp = op;
      bus.Operand1 = a;
      bus.Operand2 = b;
      e.r1 = r1; e.r2 = r2; e.name = name;
      sb.push_back(e);
      @(posedge CLK); #1;
      bus.Start    = 1'b0;
      bus.MCycleOp = 2'($urandom);
      bus.Operand1 = $urandom;
      bus.Operand2 = $urandom;
      wait_busy_low(name);
      @(posedge CLK);
   endtask

   initial begin
      exp_t e;
      bus.Start    = 1'b0;
      bus.MCycleOp = OP_SMUL;
      bus.Operand1 = '0;
      bus.Operand2 = '0;

      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("reset_busy", {63'd0, bus.Busy}, 64'd0);
      check("reset_r1", {32'd0, bus.Result1}, 64'd0);
      check("reset_r2", {32'd0, bus.Result2}, 64'd0);
      #1 RESET = 1'b0;

      run_op(OP_UMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, "umul_max");
      run_op(OP_SMUL, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF, "smul_m3x5");
      run_op(OP_SMUL, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, "smul_min2");
      run_op(OP_UDIV, 32'd100,      32'd7,        32'd14,       32'd2,        "udiv_100_7");
      run_op(OP_SDIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, "sdiv_m7_2");
      run_op(OP_SDIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, "sdiv_7_m2");
      run_op(OP_UDIV, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        "udiv_5_0");
      run_op(OP_SDIV, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, "sdiv_m5_0");
      run_op(OP_SDIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, "sdiv_min_m1");

      // Start held through DONE: second op is taken in the IDLE cycle after DONE
      @(posedge CLK); #1;
      bus.Start    = 1'b1;
      bus.MCycleOp = OP_UMUL;
      bus.Operand1 = 32'd6;
      bus.Operand2 = 32'd7;
      e.r1 = 32'd42; e.r2 = 32'd0; e.name = "held_first";
      sb.push_back(e);
      @(posedge CLK); #1;
      bus.Operand1 = 32'd3;
      bus.Operand2 = 32'd4;
      e.r1 = 32'd12; e.r2 = 32'd0; e.name = "held_second";
      sb.push_back(e);
      wait_busy_low("held_first");
      @(negedge CLK);
      check("held_restart_busy", {63'd0, bus.Busy}, 64'd1);
      @(posedge CLK); #1;
      bus.Start = 1'b0;
      wait_busy_low("held_second");
      @(posedge CLK);

      // Reset aborts an SDIV part way through
      @(posedge CLK); #1;
      bus.Start    = 1'b1;
      bus.MCycleOp = OP_SDIV;
      bus.Operand1 = 32'hFFFFFF9C;
      bus.Operand2 = 32'd7;
      @(posedge CLK); #1;
      bus.Start = 1'b0;
      repeat (9) @(posedge CLK);
      #1 RESET = 1'b1;
      #1;
      check("abort_busy", {63'd0, bus.Busy}, 64'd0);
      check("abort_r1", {32'd0, bus.Result1}, 64'd0);
      check("abort_r2", {32'd0, bus.Result2}, 64'd0);
      @(negedge CLK); #1;
      RESET = 1'b0;

      run_op(OP_UMUL, 32'd6, 32'd7, 32'd42, 32'd0, "umul_after_reset");

      repeat (2) @(posedge CLK);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
